echo_detector: RTL and testbench

Downstream consumer of the time-multiplexed FIR filter in the sonar receive path. Takes each filtered sample, rectifies it, smooths it into an envelope with a shift-based exponential moving average, and finds the first echo using a hysteresis threshold. Reports time of flight in sample periods, peak envelope and a done interrupt to the SoC register block.

---
 rtl/sonar_pkg.sv | 18 +
 rtl/envelope_ema.sv | 42 ++++
 rtl/echo_detector.sv | 141 ++++++++++++++
 tb/tb_echo_detector.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared types and constants for the sonar receive path.
//   echo_state_t : measurement FSM states of echo_detector
//   TOF_NONE     : time-of-flight value reported when no echo was found
//                  (all ones of the default 16-bit counter width)
package sonar_pkg;

    localparam int SONAR_CW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ECHO  = 2'd2,
        DONE  = 2'd3
    } echo_state_t;

    localparam logic [SONAR_CW-1:0] TOF_NONE = '1;

endpackage

// File: rtl/envelope_ema.sv
// Rectifier plus one step of a shift-based exponential moving average.
// Purely combinational; the envelope register lives in the caller.
//   x_i      : signed sample
//   env_i    : current envelope (unsigned, always within [0, 2^(N-1)-1])
//   env_nx_o : envelope after absorbing x_i
module envelope_ema #(
    parameter int N        = 16,
    parameter int ALPHA_SH = 3
) (
    input  logic signed [N-1:0] x_i,
    input  logic        [N-1:0] env_i,
    output logic        [N-1:0] env_nx_o
);

    logic        [N-1:0] rect;
    logic signed [N:0]   diff;
    logic signed [N:0]   step;
    logic signed [N:0]   sum;
    logic                sum_msb_unused;

    always_comb begin
        // |most negative| does not fit in N signed bits: clamp to the max positive.
        if (x_i == {1'b1, {(N-1){1'b0}}}) begin
            rect = {1'b0, {(N-1){1'b1}}};
        end else if (x_i[N-1]) begin
            rect = -x_i;
        end else begin
            rect = x_i;
        end

        // One extra bit keeps (rect - env) exact; the arithmetic shift rounds
        // toward minus infinity, so env can never overshoot rect.
        diff = $signed({1'b0, rect}) - $signed({1'b0, env_i});
        step = diff >>> ALPHA_SH;
        sum  = $signed({1'b0, env_i}) + step;
    end

    // sum stays in [0, 2^(N-1)-1], so the top bit is always zero.
    assign env_nx_o       = sum[N-1:0];
    assign sum_msb_unused = sum[N];

endmodule

// File: rtl/echo_detector.sv
// First-echo detector for the sonar receive path.
// Rectifies and smooths FIR output samples into an envelope, then finds the
// first echo with a hysteresis threshold and reports time of flight and peak.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : one-cycle arm pulse (beats a simultaneous in_valid)
//   in_valid, X       : sample strobe and signed sample
//   thr_hi, thr_lo    : detect / release thresholds (unsigned)
//   timeout           : max samples per measurement (0 = unlimited)
//   env, tof, peak    : envelope, first-crossing index, peak envelope
//   detected          : last measurement found an echo
//   busy, done        : state decodes (ARMED/ECHO, DONE)
//   irq               : one-cycle pulse on entry to DONE
//   dbg_state         : registered FSM state for observation
// Handshake: in_valid is a one-cycle strobe with no back-pressure; a sample is
// consumed on the edge where in_valid=1 only in ARMED or ECHO, otherwise dropped.
module echo_detector
    import sonar_pkg::*;
#(
    parameter int N        = 16,
    parameter int CW       = SONAR_CW,
    parameter int ALPHA_SH = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [N-1:0]  X,
    input  logic [N-1:0]  thr_hi,
    input  logic [N-1:0]  thr_lo,
    input  logic [CW-1:0] timeout,
    output logic [N-1:0]  env,
    output logic [CW-1:0] tof,
    output logic [N-1:0]  peak,
    output logic          detected,
    output logic          busy,
    output logic          done,
    output logic          irq,
    output echo_state_t   dbg_state
);

    localparam logic [CW-1:0] TOF_ALL_ONES = '1;

    echo_state_t   state_q, state_d;
    logic [N-1:0]  env_q, env_d;
    logic [CW-1:0] tof_q, tof_d;
    logic [N-1:0]  peak_q, peak_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          det_q, det_d;
    logic          irq_q, irq_d;

    logic [N-1:0]  env_nx;
    logic [CW-1:0] count_nx;
    logic          accept;

    envelope_ema #(
        .N        (N),
        .ALPHA_SH (ALPHA_SH)
    ) u_ema (
        .x_i      (X),
        .env_i    (env_q),
        .env_nx_o (env_nx)
    );

    // Counter saturates so timeout=0 can never be matched by a wrap.
    assign count_nx = (cnt_q == TOF_ALL_ONES) ? cnt_q : cnt_q + 1'b1;
    assign accept   = in_valid && ((state_q == ARMED) || (state_q == ECHO));

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        tof_d   = tof_q;
        peak_d  = peak_q;
        cnt_d   = cnt_q;
        det_d   = det_q;

        if (start) begin
            state_d = ARMED;
            env_d   = '0;
            tof_d   = '0;
            peak_d  = '0;
            cnt_d   = '0;
            det_d   = 1'b0;
        end else if (accept) begin
            env_d = env_nx;
            cnt_d = count_nx;
            if (state_q == ARMED) begin
                if (env_nx >= thr_hi) begin
                    state_d = ECHO;
                    tof_d   = count_nx;
                    peak_d  = env_nx;
                end else if (count_nx == timeout) begin
                    state_d = DONE;
                    det_d   = 1'b0;
                    tof_d   = TOF_ALL_ONES;
                end
            end else begin
                if (env_nx > peak_q) begin
                    peak_d = env_nx;
                end
                // Release and truncation by timeout end the same way.
                if ((env_nx < thr_lo) || (count_nx == timeout)) begin
                    state_d = DONE;
                    det_d   = 1'b1;
                end
            end
        end

        irq_d = (state_d == DONE) && (state_q != DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            env_q   <= '0;
            tof_q   <= '0;
            peak_q  <= '0;
            cnt_q   <= '0;
            det_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            tof_q   <= tof_d;
            peak_q  <= peak_d;
            cnt_q   <= cnt_d;
            det_q   <= det_d;
            irq_q   <= irq_d;
        end
    end

    assign env       = env_q;
    assign tof       = tof_q;
    assign peak      = peak_q;
    assign detected  = det_q;
    assign irq       = irq_q;
    assign busy      = (state_q == ARMED) || (state_q == ECHO);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_echo_detector.sv
module tb_echo_detector;
    import sonar_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] X = '0;
    logic [15:0] thr_hi = '0;
    logic [15:0] thr_lo = '0;
    logic [15:0] timeout = '0;

    always #5 clk = ~clk;

    // Two instances with the same stimulus: ALPHA_SH=0 and ALPHA_SH=3.
    logic [15:0] env0, tof0, peak0, env3, tof3, peak3;
    logic        det0, busy0, done0, irq0, det3, busy3, done3, irq3;
    echo_state_t st0, st3;

    echo_detector #(.N(16), .CW(16), .ALPHA_SH(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .X(X),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .timeout(timeout),
        .env(env0), .tof(tof0), .peak(peak0), .detected(det0),
        .busy(busy0), .done(done0), .irq(irq0), .dbg_state(st0)
    );

    echo_detector #(.N(16), .CW(16), .ALPHA_SH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .X(X),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .timeout(timeout),
        .env(env3), .tof(tof3), .peak(peak3), .detected(det3),
        .busy(busy3), .done(done3), .irq(irq3), .dbg_state(st3)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 waiting for echo, 2 inside echo, 3 finished
    int shift_of[2] = '{0, 3};
    int m_ph[2], m_env[2], m_tof[2], m_peak[2], m_cnt[2];
    int m_det[2], m_irq[2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = 0; m_env[k] = 0; m_tof[k] = 0; m_peak[k] = 0;
            m_cnt[k] = 0; m_det[k] = 0; m_irq[k] = 0;
        end
    endfunction

    function automatic void model_update(bit s, bit v, int xv);
        int rect;
        for (int k = 0; k < 2; k++) begin
            m_irq[k] = 0;
            if (s) begin
                m_ph[k] = 1; m_env[k] = 0; m_peak[k] = 0;
                m_cnt[k] = 0; m_det[k] = 0; m_tof[k] = 0;
            end else if (v && (m_ph[k] == 1 || m_ph[k] == 2)) begin
                rect = (xv < 0) ? -xv : xv;
                if (rect > 32767) rect = 32767;
                m_env[k] = m_env[k] + ((rect - m_env[k]) >>> shift_of[k]);
                if (m_cnt[k] < 65535) m_cnt[k]++;
                if (m_ph[k] == 1) begin
                    if (m_env[k] >= int'(thr_hi)) begin
                        m_ph[k] = 2; m_tof[k] = m_cnt[k]; m_peak[k] = m_env[k];
                    end else if (m_cnt[k] == int'(timeout)) begin
                        m_ph[k] = 3; m_det[k] = 0; m_tof[k] = 65535; m_irq[k] = 1;
                    end
                end else begin
                    if (m_env[k] > m_peak[k]) m_peak[k] = m_env[k];
                    if (m_env[k] < int'(thr_lo) || m_cnt[k] == int'(timeout)) begin
                        m_ph[k] = 3; m_det[k] = 1; m_irq[k] = 1;
                    end
                end
            end
        end
    endfunction

    function automatic echo_state_t ph_state(int ph);
        case (ph)
            1:       return ARMED;
            2:       return ECHO;
            3:       return DONE;
            default: return IDLE;
        endcase
    endfunction

    task automatic check_dut(int k);
        string t = (k == 0) ? "a0" : "a3";
        chk({t, ".env"},   int'(k ? env3  : env0),  m_env[k]);
        chk({t, ".tof"},   int'(k ? tof3  : tof0),  m_tof[k]);
        chk({t, ".peak"},  int'(k ? peak3 : peak0), m_peak[k]);
        chk({t, ".det"},   int'(k ? det3  : det0),  m_det[k]);
        chk({t, ".irq"},   int'(k ? irq3  : irq0),  m_irq[k]);
        chk({t, ".busy"},  int'(k ? busy3 : busy0), int'(m_ph[k] == 1 || m_ph[k] == 2));
        chk({t, ".done"},  int'(k ? done3 : done0), int'(m_ph[k] == 3));
        chk({t, ".state"}, int'(k ? st3   : st0),   int'(ph_state(m_ph[k])));
    endtask

    task automatic check_all();
        check_dut(0);
        check_dut(1);
    endtask

    // ---------------- driver ----------------
    task automatic step(bit s, bit v, logic [15:0] x);
        @(negedge clk);
        start = s; in_valid = v; X = x;
        @(posedge clk);
        model_update(s, v, int'($signed(x)));
        #1;
        check_all();
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic set_cfg(int hi, int lo, int to);
        thr_hi = 16'(hi); thr_lo = 16'(lo); timeout = 16'(to);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          s;
        bit          v;
        logic [15:0] x;
        int          e_env, e_tof, e_peak;
        bit          e_det, e_busy, e_done, e_irq;
    } vec_t;

    vec_t tbl[8];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int prev;
        int xs;
        model_reset();
        #12;
        #1 check_all();                      // reset values
        @(negedge clk);
        rst_n = 1'b1;

        // Detect/release with ALPHA_SH=0 (checked on dut0 from the table).
        set_cfg(500, 200, 100);
        tbl[0] = '{1'b1, 1'b0, 16'd0,      0, 0,   0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 16'd0,      0, 0,   0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 16'd0,      0, 0,   0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 16'd600,  600, 3, 600, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, -16'sd900,900, 3, 900, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 16'd300,  300, 3, 900, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 16'd100,  100, 3, 900, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 16'd0,    100, 3, 900, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].s, tbl[i].v, tbl[i].x);
            chk($sformatf("tbl%0d.env", i),  int'(env0),  tbl[i].e_env);
            chk($sformatf("tbl%0d.tof", i),  int'(tof0),  tbl[i].e_tof);
            chk($sformatf("tbl%0d.peak", i), int'(peak0), tbl[i].e_peak);
            chk($sformatf("tbl%0d.det", i),  int'(det0),  int'(tbl[i].e_det));
            chk($sformatf("tbl%0d.busy", i), int'(busy0), int'(tbl[i].e_busy));
            chk($sformatf("tbl%0d.done", i), int'(done0), int'(tbl[i].e_done));
            chk($sformatf("tbl%0d.irq", i),  int'(irq0),  int'(tbl[i].e_irq));
        end

        // EMA step response, ALPHA_SH=3.
        set_cfg(1000, 0, 0);
        step(1, 0, 0);
        step(0, 1, 16'd800);
        chk("ema.s1", int'(env3), 100);
        step(0, 1, 16'd800);
        chk("ema.s2", int'(env3), 187);
        prev = 187;
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 16'd800);
            chk("ema.mono", int'(env3 >= 16'(prev) && env3 <= 16'd800), 1);
            prev = int'(env3);
        end
        chk("ema.nodet", int'(st3), int'(ARMED));

        // Timeout without echo.
        set_cfg(1000, 0, 20);
        step(1, 0, 0);
        for (int i = 1; i <= 19; i++) step(0, 1, 16'd10);
        chk("to.s19.done", int'(done0), 0);
        step(0, 1, 16'd10);
        chk("to.done", int'(done0), 1);
        chk("to.det", int'(det0), 0);
        chk("to.tof", int'(tof0), 16'hFFFF);
        chk("to.irq", int'(irq0), 1);
        step(0, 1, 16'd10);                  // ignored in DONE
        chk("to.irq_off", int'(irq0), 0);

        // Saturation of the most negative sample.
        set_cfg(16'hFFFF, 0, 0);
        step(1, 0, 0);
        step(0, 1, 16'h8000);
        chk("sat.env", int'(env0), 16'h7FFF);
        step(0, 1, 16'h8000);
        chk("sat.env2", int'(env0), 16'h7FFF);

        // start during ECHO together with in_valid.
        set_cfg(500, 200, 100);
        step(1, 0, 0);
        step(0, 1, 16'd600);
        chk("restart.echo", int'(st0), int'(ECHO));
        step(1, 1, 16'd600);
        chk("restart.state", int'(st0), int'(ARMED));
        chk("restart.env", int'(env0), 0);
        chk("restart.peak", int'(peak0), 0);
        chk("restart.irq", int'(irq0), 0);
        step(0, 1, 16'd600);
        chk("restart.tof1", int'(tof0), 1);

        // Asynchronous reset in the middle of ARMED.
        set_cfg(1000, 0, 0);
        step(1, 0, 0);
        step(0, 1, 16'd300);
        step(0, 1, 16'd300);
        @(posedge clk);
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 1, 16'd300);

        // Randomized run against the model.
        set_cfg(300, 100, 10);
        step(1, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            bit s;
            s = ($urandom_range(0, 39) == 0) || (done0 && $urandom_range(0, 3) == 0);
            if (s) set_cfg($urandom_range(0, 3000), 0, $urandom_range(0, 40));
            if (s) thr_lo = 16'($urandom_range(0, int'(thr_hi)));
            if ($urandom_range(0, 9) == 0) xs = $urandom_range(0, 65535);
            else xs = $urandom_range(0, 8000) - 4000;
            step(s, 1'($urandom_range(0, 1)), 16'(xs));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
